// File: rtl/jtopl_op_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtopl_op_pkg                                                       |
// | Shared constants and types for the JTOPL operator output stage.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package jtopl_op_pkg;

    localparam int          OP_LAT    = 3;
    localparam int          ROM_DEPTH = 256;
    localparam logic [12:0] ATT_MAX   = 13'h1FFF;

    typedef enum logic [1:0] {
        WS_SINE  = 2'd0,
        WS_HALF  = 2'd1,
        WS_ABS   = 2'd2,
        WS_QUART = 2'd3
    } ws_e;

endpackage
`default_nettype wire

// File: rtl/jtopl_op_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtopl_op_rom                                                       |
// | Quarter-wave log-sine and exponential tables, synchronous read.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module jtopl_op_rom
    import jtopl_op_pkg::*;
(
    input  logic        clk,
    input  logic        cen,
    input  logic [7:0]  ls_addr,
    output logic [11:0] ls_data,
    input  logic [7:0]  exp_addr,
    output logic [9:0]  exp_data
);

    localparam real PI = 3.14159265358979323846;

    logic [11:0] ls_tab  [ROM_DEPTH];
    logic [9:0]  exp_tab [ROM_DEPTH];

    // Contents are fixed at elaboration from the closed-form table definitions.
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_tab
        localparam int LS_I = $rtoi(-$ln($sin((gi + 0.5) * PI / 512.0)) / $ln(2.0) * 256.0 + 0.5);
        localparam int EX_I = $rtoi(($pow(2.0, (255 - gi) / 256.0) - 1.0) * 1024.0 + 0.5);
        assign ls_tab[gi]  = LS_I[11:0];
        assign exp_tab[gi] = EX_I[9:0];
    end

    logic [11:0] ls_data_d,  ls_data_q;
    logic [9:0]  exp_data_d, exp_data_q;

    always_comb begin
        ls_data_d  = ls_tab[ls_addr];
        exp_data_d = exp_tab[exp_addr];
    end

    // No reset so the read registers can sit inside block RAM.
    always_ff @(posedge clk) begin
        if (cen) begin
            ls_data_q  <= ls_data_d;
            exp_data_q <= exp_data_d;
        end
    end

    assign ls_data  = ls_data_q;
    assign exp_data = exp_data_q;

endmodule
`default_nettype wire

// File: rtl/jtopl_op_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtopl_op_pipe                                                      |
// | Operator output stage: feedback/modulation, log-sine, exp, store.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module jtopl_op_pipe
    import jtopl_op_pkg::*;
#(
    parameter int CH_NUM = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        in_valid,
    input  logic [9:0]  phase_op,
    input  logic [9:0]  eg_atten,
    input  logic [1:0]  ws,
    input  logic [3:0]  ch,
    input  logic        is_mod,
    input  logic [2:0]  fb,
    input  logic        con,
    output logic [12:0] op_out,
    output logic        op_valid,
    output logic [3:0]  op_ch
);

    localparam logic [4:0] CH_LIM = 5'(CH_NUM);

    logic [12:0] prev0_q [CH_NUM];
    logic [12:0] prev1_q [CH_NUM];
    logic [12:0] prev0_d [CH_NUM];
    logic [12:0] prev1_d [CH_NUM];

    logic        s1_valid_q, s1_valid_d, s1_mod_q, s1_mod_d, s1_ok_q, s1_ok_d;
    logic [9:0]  s1_phase_q, s1_phase_d, s1_eg_q, s1_eg_d;
    logic [3:0]  s1_ch_q, s1_ch_d;
    ws_e         s1_ws_q, s1_ws_d;

    logic        s2_valid_q, s2_valid_d, s2_mod_q, s2_mod_d, s2_ok_q, s2_ok_d;
    logic        s2_sign_q, s2_sign_d, s2_mute_q, s2_mute_d;
    logic [9:0]  s2_eg_q, s2_eg_d;
    logic [3:0]  s2_ch_q, s2_ch_d;

    logic        s3_valid_q, s3_valid_d, s3_mod_q, s3_mod_d, s3_ok_q, s3_ok_d;
    logic        s3_sign_q, s3_sign_d;
    logic [12:0] s3_att_q, s3_att_d;
    logic [3:0]  s3_ch_q, s3_ch_d;

    logic [12:0] op_out_q, op_out_next;
    logic        op_valid_q;
    logic [3:0]  op_ch_q;

    logic        rd_ok, fwd, wr_en;
    logic [3:0]  rd_idx, wr_idx;
    logic [12:0] p0, p1;
    logic signed [13:0] fb_sum;
    logic [3:0]  fb_sh;
    logic [9:0]  fb_pm, pm;
    logic [7:0]  ls_addr;
    logic [11:0] ls_data;
    logic [9:0]  exp_data;
    logic [13:0] att_sum;
    logic [11:0] exp_base, mag;

    jtopl_op_rom u_rom (
        .clk      (clk),
        .cen      (cen),
        .ls_addr  (ls_addr),
        .ls_data  (ls_data),
        .exp_addr (s3_att_d[7:0]),
        .exp_data (exp_data)
    );

    // Exit stage: exponential scale, one's complement sign, store update.
    always_comb begin
        exp_base    = {1'b1, exp_data, 1'b0};
        mag         = exp_base >> s3_att_q[12:8];
        op_out_next = s3_sign_q ? ~{1'b0, mag} : {1'b0, mag};
        wr_en       = s3_valid_q && s3_mod_q && s3_ok_q;
        wr_idx      = s3_ok_q ? s3_ch_q : 4'd0;
        prev0_d     = prev0_q;
        prev1_d     = prev1_q;
        if (wr_en) begin
            prev0_d[wr_idx] = op_out_next;
            prev1_d[wr_idx] = prev0_q[wr_idx];
        end
    end

    // S1: the store write landing this cen is forwarded so a carrier three slots behind its modulator sees it.
    always_comb begin
        rd_ok      = ({1'b0, ch} < CH_LIM);
        rd_idx     = rd_ok ? ch : 4'd0;
        fwd        = wr_en && rd_ok && (s3_ch_q == ch);
        p0         = fwd ? op_out_next      : prev0_q[rd_idx];
        p1         = fwd ? prev0_q[rd_idx]  : prev1_q[rd_idx];
        fb_sum     = $signed({p0[12], p0}) + $signed({p1[12], p1});
        fb_sh      = 4'd10 - {1'b0, fb};
        fb_pm      = 10'(fb_sum >>> fb_sh);
        pm         = 10'd0;
        if (rd_ok) begin
            if (is_mod && (fb != 3'd0)) begin
                pm = fb_pm;
            end else if (!is_mod && !con) begin
                pm = p0[10:1];
            end
        end
        s1_phase_d = phase_op + pm;
        s1_valid_d = in_valid;
        s1_eg_d    = eg_atten;
        s1_ws_d    = ws_e'(ws);
        s1_ch_d    = ch;
        s1_mod_d   = is_mod;
        s1_ok_d    = rd_ok;
    end

    // S2: log-sine lookup address and waveform shaping.
    always_comb begin
        ls_addr    = s1_phase_q[8] ? ~s1_phase_q[7:0] : s1_phase_q[7:0];
        s2_sign_d  = s1_phase_q[9];
        s2_mute_d  = 1'b0;
        case (s1_ws_q)
            WS_HALF:  s2_mute_d = s1_phase_q[9];
            WS_ABS:   s2_sign_d = 1'b0;
            WS_QUART: begin
                s2_mute_d = s1_phase_q[8];
                s2_sign_d = 1'b0;
            end
            default:  ;
        endcase
        s2_valid_d = s1_valid_q;
        s2_eg_d    = s1_eg_q;
        s2_ch_d    = s1_ch_q;
        s2_mod_d   = s1_mod_q;
        s2_ok_d    = s1_ok_q;
    end

    // S3: saturating attenuation add; its low byte addresses the exp table.
    always_comb begin
        att_sum    = {2'b00, ls_data} + {1'b0, s2_eg_q, 3'b000};
        s3_att_d   = (s2_mute_q || att_sum[13]) ? ATT_MAX : att_sum[12:0];
        s3_sign_d  = s2_sign_q;
        s3_valid_d = s2_valid_q;
        s3_ch_d    = s2_ch_q;
        s3_mod_d   = s2_mod_q;
        s3_ok_d    = s2_ok_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_phase_q <= '0; s1_eg_q <= '0; s1_ws_q <= WS_SINE;
            s1_ch_q    <= '0;   s1_mod_q   <= 1'b0; s1_ok_q <= 1'b0;
            s2_valid_q <= 1'b0; s2_sign_q  <= 1'b0; s2_mute_q <= 1'b0; s2_eg_q <= '0;
            s2_ch_q    <= '0;   s2_mod_q   <= 1'b0; s2_ok_q <= 1'b0;
            s3_valid_q <= 1'b0; s3_sign_q  <= 1'b0; s3_att_q <= '0;
            s3_ch_q    <= '0;   s3_mod_q   <= 1'b0; s3_ok_q <= 1'b0;
            op_out_q   <= '0;   op_valid_q <= 1'b0; op_ch_q <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                prev0_q[i] <= '0;
                prev1_q[i] <= '0;
            end
        end else if (cen) begin
            s1_valid_q <= s1_valid_d; s1_phase_q <= s1_phase_d; s1_eg_q <= s1_eg_d; s1_ws_q <= s1_ws_d;
            s1_ch_q    <= s1_ch_d;    s1_mod_q   <= s1_mod_d;   s1_ok_q <= s1_ok_d;
            s2_valid_q <= s2_valid_d; s2_sign_q  <= s2_sign_d;  s2_mute_q <= s2_mute_d; s2_eg_q <= s2_eg_d;
            s2_ch_q    <= s2_ch_d;    s2_mod_q   <= s2_mod_d;   s2_ok_q <= s2_ok_d;
            s3_valid_q <= s3_valid_d; s3_sign_q  <= s3_sign_d;  s3_att_q <= s3_att_d;
            s3_ch_q    <= s3_ch_d;    s3_mod_q   <= s3_mod_d;   s3_ok_q <= s3_ok_d;
            op_out_q   <= op_out_next; op_valid_q <= s3_valid_q; op_ch_q <= s3_ch_q;
            prev0_q    <= prev0_d;
            prev1_q    <= prev1_d;
        end
    end

    assign op_out   = op_out_q;
    assign op_valid = op_valid_q;
    assign op_ch    = op_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_jtopl_op_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtopl_op_pipe                                                   |
// | Table, directed and random checks against a behavioural model.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_jtopl_op_pipe;
    import jtopl_op_pkg::*;

    localparam int  CH_NUM = 9;
    localparam real PI     = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n, cen, in_valid, is_mod, con;
    logic [9:0]  phase_op, eg_atten;
    logic [1:0]  ws;
    logic [3:0]  ch;
    logic [2:0]  fb;
    logic [12:0] op_out;
    logic        op_valid;
    logic [3:0]  op_ch;

    always #5 clk = ~clk;

    jtopl_op_pipe #(.CH_NUM(CH_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .in_valid(in_valid),
        .phase_op(phase_op), .eg_atten(eg_atten), .ws(ws), .ch(ch),
        .is_mod(is_mod), .fb(fb), .con(con),
        .op_out(op_out), .op_valid(op_valid), .op_ch(op_ch)
    );

    typedef struct {
        logic       v;
        logic [9:0] ph;
        logic [9:0] eg;
        logic [1:0] ws;
        logic [3:0] ch;
        logic       m;
        logic [2:0] fb;
        logic       c;
    } slot_t;

    typedef struct {
        bit v;
        int out;
        int ch;
        bit m;
    } res_t;

    typedef struct {
        logic [9:0]  ph;
        logic [9:0]  eg;
        logic [1:0]  ws;
        logic [12:0] exp_out;
    } vec_t;

    int   m_prev0 [16];
    int   m_prev1 [16];
    res_t pipe [OP_LAT];
    res_t last;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic slot_t mk(bit v, int ph, int eg, int w, int c_h, bit m, int f, bit c);
        slot_t s;
        s.v = v; s.ph = 10'(ph); s.eg = 10'(eg); s.ws = 2'(w);
        s.ch = 4'(c_h); s.m = m; s.fb = 3'(f); s.c = c;
        return s;
    endfunction

    function automatic int logsin_f(int i);
        real x;
        x = -$ln($sin((i + 0.5) * PI / 512.0)) / $ln(2.0) * 256.0;
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic int exp_f(int i);
        real x;
        x = ($pow(2.0, (255 - i) / 256.0) - 1.0) * 1024.0;
        return $rtoi($floor(x + 0.5));
    endfunction

    // Whole-slot evaluation from the current store contents.
    function automatic res_t model_slot(slot_t s);
        res_t r;
        int pm, phase, idx, att, mag, sum;
        bit sg, mute;
        pm = 0;
        if (s.ch < CH_NUM) begin
            if (s.m && s.fb != 0) begin
                sum = m_prev0[s.ch] + m_prev1[s.ch];
                pm  = (sum >>> (10 - int'(s.fb))) & 1023;
            end else if (!s.m && !s.c) begin
                pm = ((m_prev0[s.ch] & 8191) >> 1) & 1023;
            end
        end
        phase = (int'(s.ph) + pm) % 1024;
        idx   = phase % 512;
        if (idx >= 256) idx = 511 - idx;
        sg   = (phase >= 512);
        mute = 1'b0;
        case (s.ws)
            2'd1: mute = sg;
            2'd2: sg = 1'b0;
            2'd3: begin mute = ((phase % 512) >= 256); sg = 1'b0; end
            default: ;
        endcase
        att = mute ? 8191 : logsin_f(idx) + 8 * int'(s.eg);
        if (att > 8191) att = 8191;
        mag   = ((exp_f(att % 256) + 1024) * 2) >> (att / 256);
        r.v   = s.v;
        r.out = sg ? (8191 - mag) : mag;
        r.ch  = int'(s.ch);
        r.m   = s.m;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m_prev0[i] = 0; m_prev1[i] = 0; end
        for (int i = 0; i < OP_LAT; i++) pipe[i] = '{0, 0, 0, 0};
        last = '{0, 0, 0, 0};
    endtask

    task automatic model_cen(slot_t s);
        res_t r;
        r = pipe[OP_LAT-1];
        for (int i = OP_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        if (r.v && r.m && r.ch < CH_NUM) begin
            m_prev1[r.ch] = m_prev0[r.ch];
            m_prev0[r.ch] = (r.out >= 4096) ? r.out - 8192 : r.out;
        end
        last    = r;
        pipe[0] = model_slot(s);
    endtask

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(string name);
        check({name, ".valid"}, int'(op_valid), int'(last.v));
        if (last.v) begin
            check({name, ".out"}, int'(op_out), last.out);
            check({name, ".ch"},  int'(op_ch),  last.ch);
        end
    endtask

    task automatic step(slot_t s, bit c, string name);
        @(negedge clk);
        in_valid = s.v; phase_op = s.ph; eg_atten = s.eg; ws = s.ws;
        ch = s.ch; is_mod = s.m; fb = s.fb; con = s.c; cen = c;
        @(posedge clk);
        if (c) model_cen(s);
        #1;
        check_out(name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t  tab [13];
        slot_t idle, s;
        int    fbexp [3];

        tab[0]  = '{10'h100, 10'h000, 2'd0, 13'h0FF4};
        tab[1]  = '{10'h300, 10'h000, 2'd0, 13'h100B};
        tab[2]  = '{10'h300, 10'h000, 2'd1, 13'h1FFF};
        tab[3]  = '{10'h300, 10'h000, 2'd2, 13'h0FF4};
        tab[4]  = '{10'h100, 10'h3FF, 2'd0, 13'h0000};
        tab[5]  = '{10'h300, 10'h3FF, 2'd0, 13'h1FFF};
        tab[6]  = '{10'h100, 10'h000, 2'd3, 13'h0000};
        tab[7]  = '{10'h080, 10'h000, 2'd0, 13'h0B50};
        tab[8]  = '{10'h080, 10'h000, 2'd3, 13'h0B50};
        tab[9]  = '{10'h100, 10'h020, 2'd0, 13'h07FA};
        tab[10] = '{10'h300, 10'h010, 2'd0, 13'h14B7};
        tab[11] = '{10'h000, 10'h000, 2'd0, 13'h000C};
        tab[12] = '{10'h100, 10'h000, 2'd1, 13'h0FF4};
        fbexp   = '{32'h0FF4, 32'h100B, 32'h0FF4};

        idle = mk(0, 0, 0, 0, 0, 0, 0, 1);
        cen = 0; in_valid = 0; phase_op = 0; eg_atten = 0; ws = 0;
        ch = 0; is_mod = 0; fb = 0; con = 1;
        model_reset();

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset.out", int'(op_out), 0);
        check("reset.valid", int'(op_valid), 0);
        check("reset.ch", int'(op_ch), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table, back to back
        for (int i = 0; i < 16; i++) begin
            if (i < 13) s = mk(1, int'(tab[i].ph), int'(tab[i].eg), int'(tab[i].ws), i % CH_NUM, 0, 0, 1);
            else        s = idle;
            step(s, 1'b1, "tab");
            if (i >= 3) check("tab.const", int'(op_out), int'(tab[i-3].exp_out));
        end

        // Reset mid-stream
        for (int i = 0; i < 4; i++) step(mk(1, 'h100, 0, 0, 3, 0, 0, 1), 1'b1, "rst_pre");
        #3 rst_n = 1'b0;
        #1;
        check("rst_async.out", int'(op_out), 0);
        check("rst_async.valid", int'(op_valid), 0);
        check("rst_async.ch", int'(op_ch), 0);
        model_reset();
        @(negedge clk);
        cen = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        step(mk(1, 'h100, 0, 0, 3, 0, 0, 1), 1'b1, "rst_post");
        step(idle, 1'b1, "rst_post");
        step(idle, 1'b1, "rst_post");
        check("rst_post.early", int'(op_valid), 0);
        step(idle, 1'b1, "rst_post");
        check("rst_first.valid", int'(op_valid), 1);
        check("rst_first.out", int'(op_out), 'h0FF4);

        // Carrier modulation through the forwarding path
        step(mk(1, 'h100, 0, 0, 0, 1, 0, 0), 1'b1, "cmod");
        step(idle, 1'b1, "cmod");
        step(idle, 1'b1, "cmod");
        step(mk(1, 'h000, 0, 0, 0, 0, 0, 0), 1'b1, "cmod");
        check("cmod.mod_out", int'(op_out), 'h0FF4);
        step(idle, 1'b1, "cmod");
        step(idle, 1'b1, "cmod");
        step(idle, 1'b1, "cmod");
        check("cmod.car_out", int'(op_out), 'h1F76);

        // Feedback on channel 2, one modulator per 3-slot frame
        for (int k = 0; k < 6; k++) begin
            step(mk(1, 'h100, 0, 0, 2, 1, 7, 0), 1'b1, "fb");
            if (k >= 1 && k <= 3) check("fb.const", int'(op_out), fbexp[k-1]);
            step(idle, 1'b1, "fb");
            step(idle, 1'b1, "fb");
        end
        step(mk(1, 'h123, 0, 0, 9, 1, 7, 0), 1'b1, "ch9");
        step(mk(1, 'h055, 0, 0, 9, 0, 0, 0), 1'b1, "ch9");
        step(idle, 1'b1, "ch9");
        step(idle, 1'b1, "ch9");
        check("ch9.ch", int'(op_ch), 9);
        step(idle, 1'b1, "ch9");
        for (int k = 0; k < 3; k++) step(mk(1, 'h100, 0, 0, 2, 1, 7, 0), 1'b1, "fb_b2b");
        for (int k = 0; k < 3; k++) step(idle, 1'b1, "fb_b2b");

        // Outputs hold while cen is low
        step(mk(1, 'h300, 5, 0, 1, 0, 0, 1), 1'b1, "hold");
        step(idle, 1'b1, "hold");
        step(idle, 1'b1, "hold");
        for (int k = 0; k < 4; k++) step(mk(1, 'h2AA, 0, 0, 4, 1, 3, 0), 1'b0, "hold");

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            s = mk($urandom_range(0, 9) < 8, $urandom_range(0, 1023),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 63),
                   $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            step(s, $urandom_range(0, 4) != 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtopl_op_pipe.md
# jtopl_op_pipe

Operator output stage of the JTOPL voice path. It consumes the 10-bit operator phase produced by the phase-generator path, one slot per `cen` pulse, and the envelope attenuation for the same slot. It applies feedback or modulation, then performs log-sine and exponential table lookups and produces a 13-bit signed operator sample. A per-channel store keeps recent modulator outputs so that feedback and carrier modulation happen inside the block.

## Interface
Parameters:
- `CH_NUM`, default 9: number of channels held in the feedback store.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cen`  in  1  clock enable; each high cycle advances one slot.
- `in_valid`  in  1  slot inputs present this `cen`.
- `phase_op`  in  10  operator phase from the phase generator.
- `eg_atten`  in  10  envelope attenuation, 0 = loudest.
- `ws`  in  2  waveform: 0 sine, 1 half-sine, 2 abs-sine, 3 quarter/pulse.
- `ch`  in  4  channel index, 0..CH_NUM-1.
- `is_mod`  in  1  1 = modulator slot, 0 = carrier slot.
- `fb`  in  3  feedback level for modulator slots; 0 = off.
- `con`  in  1  1 = carrier is unmodulated (additive connection).
- `op_out`  out  13  signed operator sample.
- `op_valid`  out  1  `op_out` holds a new sample.
- `op_ch`  out  4  channel of the sample on `op_out`.

## Operation
- **Feedback store.** Each channel holds two 13-bit signed words, `prev0` (newest) and `prev1`.
  - A modulator sample leaving the pipe shifts the store: `prev1<=prev0`, `prev0<=op_out_next`.
  - A carrier sample leaving the pipe does not change the store.
- **S1, phase modulation.** The modulation term `pm` is:
  - Modulator with `fb!=0`: `pm = ((prev0+prev1) >>> (10-fb))`, truncated to 10 bits. The sum is 14-bit signed.
  - Carrier with `con=0`: `pm = prev0[10:1]`.
  - All other slots: `pm = 0`.
  - Then `phase = phase_op + pm`, taken mod 1024.
- **Forwarding.** When S1 reads channel `ch` on the same `cen` that the exit stage writes channel `ch`, S1 uses the value being written. It does not use the stale stored value.
- **S2, log-sine.**
  - Index is `phase[8] ? ~phase[7:0] : phase[7:0]`.
  - Table: 256x12 quarter-wave ROM, `round(-log2(sin((i+0.5)*pi/512))*256)`.
  - Sign is `phase[9]`.
  - Waveform muting:
    - `ws=1`: mute when `phase[9]`.
    - `ws=2`: force sign to 0.
    - `ws=3`: mute when `phase[8]`, and force sign to 0.
  - A muted slot forces the attenuation to 0x1FFF.
- **S3, attenuation add.** `att = logsin + (eg_atten<<3)`, unsigned 13-bit, saturating at 0x1FFF.
- **Exit stage, exponential.**
  - Table: 256x10 ROM, `round((2^((255-i)/256)-1)*1024)`.
  - `mag = ((exp[att[7:0]] + 1024) << 1) >> att[12:8]`, 12 bits.
  - `op_out = sign ? ~{1'b0,mag} : {1'b0,mag}`. This is one's complement, matching OPL2, so negative zero is 0x1FFF.
- **Out-of-range channel.** `in_valid` with `ch>=CH_NUM` still produces a sample. The store is not read: `pm` uses 0. The store is not written.

## Timing
- The pipeline has four register stages: S1, S2, S3, and the exit stage. All registers advance only when `cen=1`.
- Latency: inputs sampled on `cen` edge n appear on `op_out`, `op_valid` and `op_ch` after `cen` edge n+3.
- Throughput: one slot per `cen`. There is no backpressure.
- `op_valid` is the delayed copy of `in_valid`. Between `cen` pulses the outputs hold their values.
- Reset (`rst_n=0`, asynchronous):
  - All stage registers clear.
  - The feedback store clears.
  - `op_out=0`, `op_valid=0`, `op_ch=0`.
  - Reset during operation discards in-flight slots. The first valid output is 3 `cen` after the first post-reset valid input.
- OPL slot order puts a channel's carrier 3 slots after its modulator. The forwarding path guarantees the carrier sees the modulator output even with zero slack.

## Structure
- Shared package `jtopl_op_pkg`:
  - stage-count constant `OP_LAT=3`;
  - waveform enum (`WS_SINE`, `WS_HALF`, `WS_ABS`, `WS_QUART`);
  - saturation constant `ATT_MAX=13'h1FFF`.
- One sub-module, `jtopl_op_rom`, holds both lookup tables as synchronous-read ROMs so they map to block RAM.
- The feedback store stays in the top module as a register array of `CH_NUM x 2 x 13` bits.

## Test plan
- **Reset.** Assert `rst_n=0` mid-stream. Required: outputs go to 0 immediately; first output appears exactly 3 `cen` after restart.
- **Peak sine.** `phase_op=0x100`, `eg_atten=0`, `ws=0`, `fb=0`, carrier with `con=1`. Required: `op_out=+4084` (0x0FF4) after 3 `cen`. Same inputs with `phase_op=0x300`: required `op_out=~0x0FF4`.
- **Waveforms.** `ws=1` with `phase_op=0x300`: required output 0x1FFF (negative zero). `ws=2` with `phase_op=0x300`: required +4084.
- **Attenuation saturation.** `eg_atten=0x3FF` at peak phase. Required: `op_out` is 0 for positive sign and 0x1FFF for negative.
- **Carrier modulation.** Ch 0 modulator at peak (output 0x0FF4), then ch 0 carrier 3 slots later with `con=0`, `phase_op=0`. Required: the carrier uses `pm=0x3FA` via forwarding; check `op_out` against the model.
- **Feedback.** Ch 2 modulator with `fb=7` over repeated frames. Required: `prev0` and `prev1` shift correctly, and `pm = (prev0+prev1)>>>3`. Ch 9 input produces output with the store unchanged.
